// File: rtl/unspinner.sv
// Un-spinner: rotates a 32-bit word left by 0..31 in five log-shifter stages, one stage per clock.
// Define UNSPINNER_EARLY_EXIT_EN to leave the rotate loop once no higher amount bits remain.
module unspinner (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  amount,
  input  logic [31:0] din,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] dout,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ROT  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int NUM_STAGES = 5;

  state_t      state_reg;
  logic [31:0] work_reg;
  logic [4:0]  amt_reg;
  logic [2:0]  stage_reg;
  logic [31:0] dout_reg;
  logic        out_valid_reg;
  logic        busy_reg;
  logic        in_ready_reg;

  logic [31:0]           rot_cand [NUM_STAGES];
  logic [NUM_STAGES-1:0] stage_sel;
  logic [NUM_STAGES-1:0] stage_hit;
  logic [31:0]           work_next;
  logic                  last_stage;

  // Stage k rotates by the fixed distance 2^k; only the current stage's candidate is used.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_STAGES; gi++) begin : g_stage
      localparam int SH = 1 << gi;
      assign rot_cand[gi]  = (work_reg << SH) | (work_reg >> (32 - SH));
      assign stage_sel[gi] = (stage_reg == 3'(gi));
      assign stage_hit[gi] = stage_sel[gi] & amt_reg[gi];
    end
  endgenerate

  always_comb begin
    work_next = work_reg;
    for (int i = 0; i < NUM_STAGES; i++) begin
      if (stage_hit[i]) begin
        work_next = rot_cand[i];
      end
    end
  end

`ifdef UNSPINNER_EARLY_EXIT_EN
  // upper_clear[k]: no amount bits above k remain, so stage k can be the final one.
  logic [NUM_STAGES-1:0] upper_clear;
  generate
    for (gi = 0; gi < NUM_STAGES - 1; gi++) begin : g_upper
      assign upper_clear[gi] = (amt_reg[NUM_STAGES-1:gi+1] == '0);
    end
  endgenerate
  assign upper_clear[NUM_STAGES-1] = 1'b1;
  assign last_stage = |(stage_sel & upper_clear);
`else
  assign last_stage = stage_sel[NUM_STAGES-1];
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      work_reg      <= '0;
      amt_reg       <= '0;
      stage_reg     <= '0;
      dout_reg      <= '0;
      out_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
      in_ready_reg  <= 1'b1;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            work_reg  <= din;
            amt_reg   <= amount;
            stage_reg <= '0;
`ifdef UNSPINNER_EARLY_EXIT_EN
            if (amount == '0) begin
              state_reg     <= DONE;
              dout_reg      <= din;
              out_valid_reg <= 1'b1;
              busy_reg      <= 1'b0;
              in_ready_reg  <= 1'b0;
            end else begin
              state_reg    <= ROT;
              busy_reg     <= 1'b1;
              in_ready_reg <= 1'b0;
            end
`else
            state_reg    <= ROT;
            busy_reg     <= 1'b1;
            in_ready_reg <= 1'b0;
`endif
          end
        end
        ROT: begin
          work_reg  <= work_next;
          stage_reg <= stage_reg + 3'd1;
          if (last_stage) begin
            state_reg     <= DONE;
            dout_reg      <= work_next;
            out_valid_reg <= 1'b1;
            busy_reg      <= 1'b0;
          end
        end
        DONE: begin
          // Hand-off edge returns to IDLE only; a new word is taken on a later edge.
          if (out_ready) begin
            state_reg     <= IDLE;
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
          end
        end
        default: begin
          state_reg     <= IDLE;
          out_valid_reg <= 1'b0;
          busy_reg      <= 1'b0;
          in_ready_reg  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign dout      = dout_reg;
  assign busy      = busy_reg;

endmodule

// File: doc/unspinner.md
UNSPINNER -- requirements
Module: unspinner

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Port clock, input, 1, sole clock; all state SHALL update on posedge.
REQ-003 Port reset, input, 1, asynchronous active-high reset.
REQ-004 Port in_valid, input, 1, din/amount valid.
REQ-005 Port in_ready, output, 1, block can accept a word; equals (state==IDLE).
REQ-006 Port amount, input, 5, left-rotate distance 0..31.
REQ-007 Port din, input, 32, word to un-spin.
REQ-008 Port out_valid, output, 1, dout holds a finished result.
REQ-009 Port out_ready, input, 1, consumer accepts dout.
REQ-010 Port dout, output, 32, registered result.
REQ-011 Port busy, output, 1, high in ROT state.

Function
REQ-012 Result SHALL equal din rotated left by amount, so that it inverts a right-rotate by the same amount.
REQ-013 The FSM SHALL have three states: IDLE, ROT and DONE.
REQ-014 Accept SHALL occur on an edge where state==IDLE and in_valid=1: work<=din, amt<=amount, stage<=0, state<=ROT.
REQ-015 In IDLE with in_valid=0, the FSM SHALL hold all state.
REQ-016 Each ROT edge SHALL process one stage k=stage: if amt[k]=1, work<=rotl(work, 2^k), else work unchanged; then stage<=stage+1.
REQ-017 After the stage-4 edge, the FSM SHALL set state<=DONE and dout<=final work value.
REQ-018 Base latency SHALL be fixed: accept edge plus 5 ROT edges, with out_valid high in the cycle after the 5th ROT edge.
REQ-019 In DONE, out_valid SHALL be 1, and dout SHALL stay stable until out_ready=1 is sampled on an edge, which sets state<=IDLE.
REQ-020 out_valid=0 SHALL hold in IDLE and ROT.
REQ-021 in_ready=0 SHALL hold in ROT and DONE, and a new input SHALL NOT be accepted on the same edge that DONE hands off.
REQ-022 in_valid and din changes during ROT/DONE SHALL be ignored.
REQ-023 Rotate arithmetic SHALL be modulo 32, with no bits lost; amount=0 SHALL return din unchanged.
REQ-024 The stage counter SHALL be 3 bits and SHALL never exceed 5.
REQ-025 dout SHALL retain its last value in IDLE and ROT.

Reset
REQ-026 Reset assertion SHALL take effect immediately, independent of clock.
REQ-027 Reset SHALL force state=IDLE, work=0, amt=0, stage=0, dout=0, out_valid=0, busy=0, in_ready=1.
REQ-028 Reset mid-ROT or mid-DONE SHALL discard the operation with no output.
REQ-029 The first accept SHALL be possible on the first edge after reset deassertion.

Configuration
REQ-030 Macro UNSPINNER_EARLY_EXIT_EN SHALL select early-exit behaviour.
REQ-031 When UNSPINNER_EARLY_EXIT_EN is defined, the FSM SHALL leave ROT after stage k when amt[4:k+1]==0.
REQ-032 When UNSPINNER_EARLY_EXIT_EN is defined and amount==0 at accept, the FSM SHALL go directly to DONE with dout<=din.
REQ-033 With early exit, latency SHALL be (index of highest set amount bit + 1) ROT edges.
REQ-034 When UNSPINNER_EARLY_EXIT_EN is undefined, latency SHALL always be 5 ROT edges.
REQ-035 Results SHALL be identical in both configurations.

Verification
REQ-036 Scenario: din=32'h0000_0001, amount=1, out_ready=1 -> dout=32'h0000_0002 with out_valid after 5 ROT edges (macro off).
REQ-037 Scenario: din=32'h8000_0000, amount=1 -> dout=32'h0000_0001; din=32'h0000_0001, amount=31 -> dout=32'h8000_0000.
REQ-038 Scenario: random X; right-rotate X by n (n=0..31) and feed with amount=n -> dout=X for all 32 n.
REQ-039 Scenario: out_ready low 3 cycles in DONE -> dout and out_valid stable and in_ready=0; out_ready=1 -> IDLE next edge.
REQ-040 Scenario: reset pulse after the 2nd ROT edge -> immediately out_valid=0, dout=0, in_ready=1; next accept of 32'hDEAD_BEEF, amount=4 -> 32'hEADB_EEFD.
REQ-041 Scenario (macro on): amount=0 -> out_valid the cycle after accept; amount=5'b00010 -> DONE after 2 ROT edges.
